// File: rtl/regfile_wb_arb_pkg.sv
// Shared widths, register count and grant encoding for the register-file writeback arbiter.
package regfile_wb_arb_pkg;

  localparam int ADDR_W           = 5;
  localparam int DATA_W           = 64;
  localparam int NUM_REGS         = 32;
  localparam int STARVE_W         = 4;
  localparam int STARVE_MAX_LIMIT = 15;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_P0   = 2'd1,
    GRANT_P1   = 2'd2
  } grant_e;

  // Keeps an out-of-range starvation limit inside what the counter can hold.
  function automatic int clamp_starve(input int val);
    if (val < 1) return 1;
    if (val > STARVE_MAX_LIMIT) return STARVE_MAX_LIMIT;
    return val;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module regfile_scoreboard
  import regfile_wb_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  output reg_mask_t busy
);

  reg_mask_t busy_reg;
  reg_mask_t set_mask;
  reg_mask_t clr_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_mask
      if (gi == 0) begin : g_x0
        assign set_mask[gi] = 1'b0;
        assign clr_mask[gi] = 1'b0;
      end else begin : g_xn
        assign set_mask[gi] = set_en && (set_addr == ADDR_W'(gi));
        assign clr_mask[gi] = clr_en && (clr_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  // Set is applied after clear so a same-address collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg & ~clr_mask) | set_mask;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/regfile_wb_arb.sv
// Two-port register-file writeback arbiter with port-1 starvation guard.
// Optional pending-write scoreboard built when REGFILE_SCOREBOARD_EN is defined.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_valid_i,
  output logic                p0_ready_o,
  input  logic [ADDR_W-1:0]   p0_addr_i,
  input  logic [DATA_W-1:0]   p0_data_i,
  input  logic                p1_valid_i,
  output logic                p1_ready_o,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic [DATA_W-1:0]   p1_data_i,
  input  logic                rsv_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  output logic                we_o,
  output logic [ADDR_W-1:0]   waddr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [NUM_REGS-1:0] busy_o
);

  localparam int STARVE_CAP = clamp_starve(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_reg;
  logic [STARVE_W-1:0] starve_cnt_next;
  logic                force1;
  grant_e              grant;
  reg_addr_t           sel_addr;
  reg_data_t           sel_data;
  logic                we_next;
  logic                we_reg;
  reg_addr_t           waddr_reg;
  reg_data_t           wdata_reg;

  assign force1     = (starve_cnt_reg == STARVE_W'(STARVE_CAP));
  assign p0_ready_o = !(p1_valid_i && force1);
  assign p1_ready_o = !p0_valid_i || force1;

  // Ready logic guarantees at most one port fires; reset suppresses recording.
  always_comb begin
    grant    = GRANT_NONE;
    sel_addr = '0;
    sel_data = '0;
    if (!rst) begin
      if (p0_valid_i && p0_ready_o) begin
        grant    = GRANT_P0;
        sel_addr = p0_addr_i;
        sel_data = p0_data_i;
      end else if (p1_valid_i && p1_ready_o) begin
        grant    = GRANT_P1;
        sel_addr = p1_addr_i;
        sel_data = p1_data_i;
      end
    end
  end

  assign we_next = (grant != GRANT_NONE) && (sel_addr != '0);

  always_comb begin
    starve_cnt_next = '0;
    if (p1_valid_i && (grant != GRANT_P1)) begin
      starve_cnt_next = force1 ? starve_cnt_reg : starve_cnt_reg + STARVE_W'(1);
    end
  end

  // Address/data hold unless a real register write is launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      we_reg         <= 1'b0;
      waddr_reg      <= '0;
      wdata_reg      <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      we_reg         <= we_next;
      if (we_next) begin
        waddr_reg <= sel_addr;
        wdata_reg <= sel_data;
      end
    end
  end

  assign we_o    = we_reg;
  assign waddr_o = waddr_reg;
  assign wdata_o = wdata_reg;

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (rsv_i),
    .set_addr (rsv_addr_i),
    .clr_en   (grant == GRANT_P1),
    .clr_addr (p1_addr_i),
    .busy     (busy_o)
  );
`else
  logic unused_rsv;
  assign unused_rsv = &{1'b0, rsv_i, rsv_addr_i};
  assign busy_o     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed-vector bench for regfile_wb_arb: stimulus queues expected writes, a monitor checks them.
module tb_regfile_wb_arb;
  import regfile_wb_arb_pkg::*;

`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid_i, p1_valid_i, rsv_i;
  logic        p0_ready_o, p1_ready_o, we_o;
  logic [4:0]  p0_addr_i, p1_addr_i, rsv_addr_i, waddr_o;
  logic [63:0] p0_data_i, p1_data_i, wdata_o;
  logic [31:0] busy_o;

  always #5 clk = ~clk;

  regfile_wb_arb #(.STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0_valid_i (p0_valid_i),
    .p0_ready_o (p0_ready_o),
    .p0_addr_i  (p0_addr_i),
    .p0_data_i  (p0_data_i),
    .p1_valid_i (p1_valid_i),
    .p1_ready_o (p1_ready_o),
    .p1_addr_i  (p1_addr_i),
    .p1_data_i  (p1_data_i),
    .rsv_i      (rsv_i),
    .rsv_addr_i (rsv_addr_i),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle the DUT writes, the oldest expected write must match it.
  always @(negedge clk) begin
    exp_t e;
    if (we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_write: got addr %0d data 0x%0h at cycle %0d, expected no write",
                 waddr_o, wdata_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_cycle", 64'(cyc), 64'(e.cyc));
        chk("wb_addr", 64'(waddr_o), 64'(e.addr));
        chk("wb_data", wdata_o, e.data);
        $display("write cyc %0d addr %0d data 0x%0h", cyc, waddr_o, wdata_o);
      end
    end
  end

  task automatic step(input string tag, input logic r,
                      input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                      input logic rv, input logic [4:0] ra,
                      input logic e0r, input logic e1r, input logic [31:0] ebusy);
    exp_t e;
    @(negedge clk);
    rst = r;
    p0_valid_i = v0; p0_addr_i = a0; p0_data_i = d0;
    p1_valid_i = v1; p1_addr_i = a1; p1_data_i = d1;
    rsv_i = rv; rsv_addr_i = ra;
    #1;
    chk({tag, "/p0_ready"}, 64'(p0_ready_o), 64'(e0r));
    chk({tag, "/p1_ready"}, 64'(p1_ready_o), 64'(e1r));
    chk({tag, "/busy"}, 64'(busy_o), 64'(SB_EN ? ebusy : 32'h0));
    if (!r) begin
      if (v0 && e0r && a0 != 5'd0) begin
        e.addr = a0; e.data = d0; e.cyc = cyc + 1; exp_q.push_back(e);
      end else if (v1 && e1r && !(v0 && e0r) && a1 != 5'd0) begin
        e.addr = a1; e.data = d1; e.cyc = cyc + 1; exp_q.push_back(e);
      end
    end
    $display("cyc %0d %s: rst %0b p0 %0b/%0b p1 %0b/%0b busy 0x%0h",
             cyc, tag, r, v0, p0_ready_o, v1, p1_ready_o, busy_o);
  endtask

  task automatic idle(input string tag, input logic [31:0] ebusy);
    step(tag, 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 1, 1, ebusy);
  endtask

  task automatic both(input string tag, input int i, input logic p1_wins, input logic [31:0] ebusy);
    step(tag, 0, 1, 5'd1, 64'h10 + 64'(i), 1, 5'd2, 64'h20 + 64'(i), 0, 5'd0,
         !p1_wins, p1_wins, ebusy);
  endtask

  initial begin
    rst = 1'b1;
    p0_valid_i = 1'b1; p0_addr_i = 5'd3; p0_data_i = 64'hFFFF;
    p1_valid_i = 1'b1; p1_addr_i = 5'd4; p1_data_i = 64'hEEEE;
    rsv_i = 1'b1; rsv_addr_i = 5'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset/we", 64'(we_o), 64'h0);
    chk("reset/waddr", 64'(waddr_o), 64'h0);
    chk("reset/wdata", wdata_o, 64'h0);
    chk("reset/busy", 64'(busy_o), 64'h0);
    chk("reset/p0_ready", 64'(p0_ready_o), 64'h1);
    chk("reset/p1_ready", 64'(p1_ready_o), 64'h0);

    // Single port-0 write, then addr-0 write and x0 reservation.
    step("p0_a5", 0, 1, 5'd5, 64'h1111, 0, 5'd0, 64'h0, 0, 5'd0, 1, 0, 32'h0);
    idle("idle", 32'h0);
    step("p0_a0_rsv0", 0, 1, 5'd0, 64'hDEAD, 0, 5'd0, 64'h0, 1, 5'd0, 1, 0, 32'h0);
    idle("after_a0", 32'h0);
    chk("hold/waddr", 64'(waddr_o), 64'd5);
    chk("hold/wdata", wdata_o, 64'h1111);

    // Reserve x7, retire it from port 1 three cycles later.
    step("rsv7", 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 5'd7, 1, 1, 32'h0);
    idle("wait7a", 32'h80);
    idle("wait7b", 32'h80);
    step("p1_a7", 0, 0, 5'd0, 64'h0, 1, 5'd7, 64'hABCD, 0, 5'd0, 1, 1, 32'h80);
    idle("after7", 32'h0);

    // Set wins over clear on x9; different addresses both apply.
    step("rsv9", 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 5'd9, 1, 1, 32'h0);
    step("rsv9_p1_a9", 0, 0, 5'd0, 64'h0, 1, 5'd9, 64'h9999, 1, 5'd9, 1, 1, 32'h200);
    idle("after9", 32'h200);
    step("rsv12_p1_a9", 0, 0, 5'd0, 64'h0, 1, 5'd9, 64'h2222, 1, 5'd12, 1, 1, 32'h200);
    idle("after12", 32'h1000);
    step("p0_a12", 0, 1, 5'd12, 64'h3333, 0, 5'd0, 64'h0, 0, 5'd0, 1, 0, 32'h1000);
    idle("after_p0_a12", 32'h1000);

    // Starvation guard: port 1 forced after four losses.
    for (int i = 0; i < 6; i++) both("starve", i, (i == 4), 32'h1000);
    idle("clr_a", 32'h1000);
    for (int i = 0; i < 3; i++) both("partial", i, 1'b0, 32'h1000);
    idle("clr_b", 32'h1000);
    for (int i = 0; i < 5; i++) both("restart", i, (i == 4), 32'h1000);

    // Reset one cycle after an accepted transfer, with x3 busy.
    step("rsv3", 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 5'd3, 1, 1, 32'h1000);
    step("pre_rst", 0, 1, 5'd4, 64'h4444, 1, 5'd5, 64'h5555, 0, 5'd0, 1, 0, 32'h1008);
    step("in_rst", 1, 1, 5'd6, 64'h6666, 1, 5'd5, 64'h5555, 0, 5'd0, 1, 0, 32'h1008);
    step("post_rst", 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 1, 1, 32'h0);
    chk("post_rst/we", 64'(we_o), 64'h0);
    chk("post_rst/waddr", 64'(waddr_o), 64'h0);
    for (int i = 0; i < 5; i++) both("after_rst", i, (i == 4), 32'h0);

    idle("drain", 32'h0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
